// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, RUN/WAIT fetch FSM and IF/ID pipeline register.
// Optional stall-cycle counter enabled by defining IF_STALL_CNT_EN.
module if_stage (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [31:0] branch_target_i,
   input  logic [31:0] imem_inst_i,
   input  logic        imem_ready_i,
   output logic [31:0] imem_addr_o,
   output logic [31:0] inst_o,
   output logic [31:0] pc4_o,
   output logic        valid_o,
   output logic        fetch_wait_o,
   output logic [31:0] stall_cnt_o
);

   typedef enum logic [0:0] {StRun, StWait} state_e;

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] inst_q;
   logic [31:0] pc4_q;
   logic        valid_q;
   logic [31:0] pc_plus4;

   // Natural 32-bit wrap gives the modulo-2^32 increment.
   assign pc_plus4 = pc_q + 32'd4;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= StRun;
         pc_q    <= 32'h0;
         inst_q  <= 32'h0;
         pc4_q   <= 32'h0;
         valid_q <= 1'b0;
      end else if (flush_i) begin
         state_q <= StRun;
         pc_q    <= branch_target_i;
         inst_q  <= 32'h0;
         pc4_q   <= 32'h0;
         valid_q <= 1'b0;
      end else if (stall_i) begin
         state_q <= state_q;
      end else if (!imem_ready_i) begin
         // Memory not ready: insert a bubble and keep fetching the same PC.
         state_q <= StWait;
         inst_q  <= 32'h0;
         pc4_q   <= 32'h0;
         valid_q <= 1'b0;
      end else begin
         state_q <= StRun;
         pc_q    <= pc_plus4;
         inst_q  <= imem_inst_i;
         pc4_q   <= pc_plus4;
         valid_q <= 1'b1;
      end
   end

   assign imem_addr_o  = pc_q;
   assign inst_o       = inst_q;
   assign pc4_o        = pc4_q;
   assign valid_o      = valid_q;
   assign fetch_wait_o = (state_q == StWait);

`ifdef IF_STALL_CNT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         stall_cnt_q <= 32'h0;
      end else if (stall_i && !flush_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`else
   assign stall_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage; stall counter expectations follow IF_STALL_CNT_EN.
module tb_if_stage;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        stall_i = 1'b0;
   logic        flush_i = 1'b0;
   logic [31:0] branch_target_i = 32'h0;
   logic [31:0] imem_inst_i = 32'h0;
   logic        imem_ready_i = 1'b0;
   logic [31:0] imem_addr_o;
   logic [31:0] inst_o;
   logic [31:0] pc4_o;
   logic        valid_o;
   logic        fetch_wait_o;
   logic [31:0] stall_cnt_o;

   int checks = 0;
   int errors = 0;

`ifdef IF_STALL_CNT_EN
   localparam bit CntEn = 1'b1;
`else
   localparam bit CntEn = 1'b0;
`endif

   localparam logic [31:0] InstA = 32'h0010_0093;
   localparam logic [31:0] InstB = 32'h0020_0113;
   localparam logic [31:0] InstC = 32'h0030_0193;
   localparam logic [31:0] InstD = 32'hDEAD_BEEF;
   localparam logic [31:0] InstE = 32'h1234_5678;

   if_stage dut (
      .clk_i          (clk_i),
      .rst_n_i        (rst_n_i),
      .stall_i        (stall_i),
      .flush_i        (flush_i),
      .branch_target_i(branch_target_i),
      .imem_inst_i    (imem_inst_i),
      .imem_ready_i   (imem_ready_i),
      .imem_addr_o    (imem_addr_o),
      .inst_o         (inst_o),
      .pc4_o          (pc4_o),
      .valid_o        (valid_o),
      .fetch_wait_o   (fetch_wait_o),
      .stall_cnt_o    (stall_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [31:0] addr, input logic [31:0] inst,
                            input logic [31:0] pc4, input logic valid, input logic fwait);
      check({tag, "_addr"}, imem_addr_o, addr);
      check({tag, "_inst"}, inst_o, inst);
      check({tag, "_pc4"}, pc4_o, pc4);
      check({tag, "_valid"}, {31'h0, valid_o}, {31'h0, valid});
      check({tag, "_wait"}, {31'h0, fetch_wait_o}, {31'h0, fwait});
   endtask

   initial begin
      // Reset
      rst_n_i = 1'b0;
      imem_ready_i = 1'b1;
      step();
      check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      check("reset_cnt", stall_cnt_o, 32'h0);

      // Sequential fetch A, B
      rst_n_i = 1'b1;
      imem_inst_i = InstA;
      step();
      check_all("fetch_a", 32'h4, InstA, 32'h4, 1'b1, 1'b0);
      imem_inst_i = InstB;
      step();
      check_all("fetch_b", 32'h8, InstB, 32'h8, 1'b1, 1'b0);

      // Three stall cycles hold B and PC 8
      stall_i = 1'b1;
      imem_inst_i = InstC;
      for (int i = 0; i < 3; i++) begin
         step();
         check_all("stall", 32'h8, InstB, 32'h8, 1'b1, 1'b0);
      end
      check("stall_cnt3", stall_cnt_o, CntEn ? 32'd3 : 32'd0);

      stall_i = 1'b0;
      step();
      check_all("fetch_c", 32'hC, InstC, 32'hC, 1'b1, 1'b0);

      // Flush beats stall; counter does not advance
      flush_i = 1'b1;
      stall_i = 1'b1;
      branch_target_i = 32'h40;
      step();
      check_all("flush_stall", 32'h40, 32'h0, 32'h0, 1'b0, 1'b0);
      check("flush_cnt", stall_cnt_o, CntEn ? 32'd3 : 32'd0);

      // Unaligned redirect keeps low bits
      stall_i = 1'b0;
      branch_target_i = 32'h42;
      step();
      check("flush_unaligned", imem_addr_o, 32'h42);

      // Redirect to 0x10, then memory not ready for two cycles
      branch_target_i = 32'h10;
      step();
      check("flush_10", imem_addr_o, 32'h10);
      flush_i = 1'b0;
      imem_ready_i = 1'b0;
      step();
      check_all("wait1", 32'h10, 32'h0, 32'h0, 1'b0, 1'b1);
      step();
      check_all("wait2", 32'h10, 32'h0, 32'h0, 1'b0, 1'b1);

      // Stall while waiting: ready ignored, stays in WAIT
      stall_i = 1'b1;
      imem_ready_i = 1'b1;
      imem_inst_i = InstD;
      step();
      check_all("wait_stall", 32'h10, 32'h0, 32'h0, 1'b0, 1'b1);
      check("wait_stall_cnt", stall_cnt_o, CntEn ? 32'd4 : 32'd0);

      // Ready returns
      stall_i = 1'b0;
      step();
      check_all("wait_exit", 32'h14, InstD, 32'h14, 1'b1, 1'b0);

      // Wrap-around at top of address space
      flush_i = 1'b1;
      branch_target_i = 32'hFFFF_FFFC;
      step();
      check("flush_top", imem_addr_o, 32'hFFFF_FFFC);
      flush_i = 1'b0;
      imem_inst_i = InstE;
      step();
      check_all("wrap", 32'h0, InstE, 32'h0, 1'b1, 1'b0);

      // Enter WAIT, then reset with stall asserted
      imem_ready_i = 1'b0;
      step();
      check("wait_again", {31'h0, fetch_wait_o}, 32'h1);
      rst_n_i = 1'b0;
      stall_i = 1'b1;
      flush_i = 1'b1;
      branch_target_i = 32'h80;
      step();
      check_all("reset_mid_wait", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      check("reset_mid_cnt", stall_cnt_o, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL use one clock and one reset: clk_i; reset is synchronous and active-low, rst_n_i.
REQ-002 clk_i  input  1  rising-edge clock for all state.
REQ-003 rst_n_i  input  1  synchronous active-low reset, sampled on rising clk_i.
REQ-004 stall_i  input  1  hazard stall from decode; hold PC and IF/ID.
REQ-005 flush_i  input  1  taken branch/jump resolved in ID; redirect PC, squash IF/ID.
REQ-006 branch_target_i  input  32  redirect address, used when flush_i=1.
REQ-007 imem_inst_i  input  32  instruction word at imem_addr_o.
REQ-008 imem_ready_i  input  1  imem_inst_i valid this cycle.
REQ-009 imem_addr_o  output  32  fetch address; combinationally equal to PC register.
REQ-010 inst_o  output  32  IF/ID instruction to decode; NOP is 32'h0.
REQ-011 pc4_o  output  32  IF/ID PC+4 of inst_o.
REQ-012 valid_o  output  1  inst_o holds a real fetched instruction.
REQ-013 fetch_wait_o  output  1  1 while state is WAIT.
REQ-014 stall_cnt_o  output  32  stall-cycle counter (see Configuration).

Function
REQ-015 Two states: RUN and WAIT; all registers update only on rising clk_i.
REQ-016 Per-edge priority when rst_n_i=1: flush_i > stall_i > imem_ready_i.
REQ-017 flush_i=1 (regardless of stall_i, imem_ready_i): PC<=branch_target_i; inst_o<=0; pc4_o<=0; valid_o<=0; state<=RUN.
REQ-018 flush_i=0, stall_i=1: PC, inst_o, pc4_o, valid_o, state all hold.
REQ-019 flush_i=0, stall_i=0, imem_ready_i=0: PC holds; inst_o<=0, pc4_o<=0, valid_o<=0 (bubble); state<=WAIT.
REQ-020 flush_i=0, stall_i=0, imem_ready_i=1: inst_o<=imem_inst_i; pc4_o<=PC+4; valid_o<=1; PC<=PC+4; state<=RUN.
REQ-021 PC+4 SHALL be computed modulo 2^32; 32'hFFFFFFFC advances to 32'h00000000.
REQ-022 PC bits [1:0] SHALL be taken unmodified from branch_target_i; no alignment check.
REQ-023 Latency: instruction presented with imem_ready_i=1 at edge N appears on inst_o after edge N; one-cycle IF-to-ID.
REQ-024 WAIT exits to RUN on the first edge with imem_ready_i=1 and stall_i=0, or with flush_i=1.

Reset
REQ-025 On a rising clk_i with rst_n_i=0: PC<=0, inst_o<=0, pc4_o<=0, valid_o<=0, state<=RUN, stall counter<=0; reset overrides all inputs.
REQ-026 Reset asserted mid-stall, mid-WAIT or coincident with flush_i SHALL give the same result as REQ-025.
REQ-027 fetch_wait_o=0 and imem_addr_o=0 the cycle after reset.

Configuration
REQ-028 Macro IF_STALL_CNT_EN: defined -> counter increments by 1 on each edge with rst_n_i=1, stall_i=1, flush_i=0, saturating at 32'hFFFFFFFF; stall_cnt_o shows it.
REQ-029 IF_STALL_CNT_EN undefined -> no counter register; stall_cnt_o tied to 32'h0; all other behaviour identical.

Verification
REQ-030 Reset, then imem_ready_i=1 with insts A,B,C at PC 0,4,8 -> inst_o=A,B,C on successive cycles; pc4_o=4,8,12; valid_o=1.
REQ-031 stall_i=1 for 3 cycles after B is in IF/ID -> inst_o=B, imem_addr_o=8 held 3 cycles; stall_cnt_o=3 with macro, 0 without.
REQ-032 flush_i=1 with stall_i=1, branch_target_i=32'h40 -> next cycle imem_addr_o=32'h40, inst_o=0, valid_o=0, stall_cnt_o unchanged.
REQ-033 imem_ready_i=0 for 2 cycles at PC 32'h10 -> fetch_wait_o=1, valid_o=0, PC held 32'h10; ready returns -> fetched inst, pc4_o=32'h14.
REQ-034 branch_target_i=32'hFFFFFFFC, then ready -> pc4_o=0, imem_addr_o wraps to 0; rst_n_i=0 mid-WAIT -> all outputs 0 next cycle.
